// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared FSM states, owner codes and latency-counter width for dmem_arbiter
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;
  localparam logic OWN_C = 1'b0;
  localparam logic OWN_D = 1'b1;
  localparam int CNT_W = 4;
endpackage

// File: rtl/dmem_rr_pick.sv
// dmem_rr_pick: combinational 2-way picker between CPU port C and debug port D.
// Ports: i_c_req/i_d_req requests, i_last most recent grantee, i_cpu_priority (1 = C wins ties),
//        o_grant_valid any request present, o_grant_id winner (OWN_C/OWN_D).
module dmem_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic i_c_req,
  input  logic i_d_req,
  input  logic i_last,
  input  logic i_cpu_priority,
  output logic o_grant_valid,
  output logic o_grant_id
);
  assign o_grant_valid = i_c_req || i_d_req;
  // round-robin tie goes to whichever port did not win last
  assign o_grant_id = (i_c_req && i_d_req) ? (i_cpu_priority ? OWN_C : ~i_last)
                    : (i_d_req ? OWN_D : OWN_C);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between CPU port C and debug port D.
// Ports: clk/rst_n; i_{c,d}_req/we/addr/wdata/mask request side; o_{c,d}_ack/rdata completion;
//        o_mem_* drive data_memory, i_mem_read_data returns from it; o_busy (not IDLE), o_owner (last grantee).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MEM_LATENCY  = 1,
  parameter int CPU_PRIORITY = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_c_req,
  input  logic        i_c_we,
  input  logic [31:0] i_c_addr,
  input  logic [31:0] i_c_wdata,
  input  logic [3:0]  i_c_mask,
  input  logic        i_d_req,
  input  logic        i_d_we,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  input  logic [3:0]  i_d_mask,
  output logic        o_c_ack,
  output logic [31:0] o_c_rdata,
  output logic        o_d_ack,
  output logic [31:0] o_d_rdata,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_write_data,
  output logic        o_mem_memwrite,
  output logic        o_mem_memread,
  output logic [3:0]  o_mem_sign_mask,
  input  logic [31:0] i_mem_read_data,
  output logic        o_busy,
  output logic        o_owner
);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(MEM_LATENCY - 1);
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0] r_addr, r_wdata, r_c_rdata, r_d_rdata;
  logic [3:0] r_mask;
  logic r_we, r_owner, w_gv, w_gid;
  dmem_rr_pick u_pick (
    .i_c_req       (i_c_req),
    .i_d_req       (i_d_req),
    .i_last        (r_owner),
    .i_cpu_priority(CPU_PRIORITY != 0),
    .o_grant_valid (w_gv),
    .o_grant_id    (w_gid)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    o_mem_addr = '0;
    o_mem_write_data = '0;
    o_mem_sign_mask = '0;
    o_mem_memwrite = 1'b0;
    o_mem_memread = 1'b0;
    o_c_ack = 1'b0;
    o_d_ack = 1'b0;
    case (r_state)
      IDLE: w_next = w_gv ? ACCESS : IDLE;
      ACCESS: begin
        o_mem_addr = r_addr;
        o_mem_write_data = r_wdata;
        o_mem_sign_mask = r_mask;
        // counter still at its load value only on the first ACCESS cycle
        o_mem_memwrite = r_we && r_cnt == LOAD;
        o_mem_memread = !r_we;
        w_next = r_cnt == '0 ? DONE : ACCESS;
      end
      DONE: begin
        o_c_ack = r_owner == OWN_C;
        o_d_ack = r_owner == OWN_D;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt <= '0;
      r_addr <= '0;
      r_wdata <= '0;
      r_mask <= '0;
      r_we <= 1'b0;
      r_owner <= OWN_D;
      r_c_rdata <= '0;
      r_d_rdata <= '0;
    end else if (r_state == IDLE && w_gv) begin
      r_addr <= w_gid ? i_d_addr : i_c_addr;
      r_wdata <= w_gid ? i_d_wdata : i_c_wdata;
      r_mask <= w_gid ? i_d_mask : i_c_mask;
      r_we <= w_gid ? i_d_we : i_c_we;
      r_owner <= w_gid;
      r_cnt <= LOAD;
    end else if (r_state == ACCESS) begin
      if (r_cnt == '0) begin
        if (!r_we && r_owner == OWN_C) r_c_rdata <= i_mem_read_data;
        if (!r_we && r_owner == OWN_D) r_d_rdata <= i_mem_read_data;
      end else r_cnt <= r_cnt - 1'b1;
    end
  assign o_c_rdata = r_c_rdata;
  assign o_d_rdata = r_d_rdata;
  assign o_busy = r_state != IDLE;
  assign o_owner = r_owner;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench; dut1 = latency 1 round-robin, dut2 = latency 3 CPU priority
module tb_dmem_arbiter;
  typedef struct {logic port; logic [31:0] rdata; int cyc;} exp_t;
  logic clk = 0, rst_n = 0, rst_n2 = 0;
  int cyc = 0, checks = 0, errors = 0, k, n, r0, w0;
  exp_t q1[$], q2[$];
  exp_t e1, e2;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  logic cr1 = 0, cw1 = 0, dr1 = 0, dw1 = 0, cr2 = 0, cw2 = 0, dr2 = 0, dw2 = 0;
  logic [31:0] ca_1 = 0, cwd1 = 0, da_1 = 0, dwd1 = 0, ca_2 = 0, cwd2 = 0, da_2 = 0, dwd2 = 0;
  logic [3:0] cm1 = 0, dm1 = 0, cm2 = 0, dm2 = 0;
  logic ack_c1, ack_d1, ack_c2, ack_d2, mw1, mr1, mw2, mr2, busy1, busy2, own1, own2;
  logic [31:0] crd1, drd1, crd2, drd2, ma1, mwd1, ma2, mwd2, mrd1, mrd2;
  logic [3:0] mm1, mm2;
  logic [31:0] mem1 [0:63];
  logic [31:0] rcnt2 = 0;
  int rd1 = 0, wr1 = 0, rd2 = 0;
  logic [31:0] wa1 = 0;
  dmem_arbiter #(.MEM_LATENCY(1), .CPU_PRIORITY(0)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_c_req(cr1), .i_c_we(cw1), .i_c_addr(ca_1), .i_c_wdata(cwd1), .i_c_mask(cm1),
    .i_d_req(dr1), .i_d_we(dw1), .i_d_addr(da_1), .i_d_wdata(dwd1), .i_d_mask(dm1),
    .o_c_ack(ack_c1), .o_c_rdata(crd1), .o_d_ack(ack_d1), .o_d_rdata(drd1),
    .o_mem_addr(ma1), .o_mem_write_data(mwd1), .o_mem_memwrite(mw1), .o_mem_memread(mr1),
    .o_mem_sign_mask(mm1), .i_mem_read_data(mrd1), .o_busy(busy1), .o_owner(own1));
  dmem_arbiter #(.MEM_LATENCY(3), .CPU_PRIORITY(1)) dut2 (
    .clk(clk), .rst_n(rst_n2),
    .i_c_req(cr2), .i_c_we(cw2), .i_c_addr(ca_2), .i_c_wdata(cwd2), .i_c_mask(cm2),
    .i_d_req(dr2), .i_d_we(dw2), .i_d_addr(da_2), .i_d_wdata(dwd2), .i_d_mask(dm2),
    .o_c_ack(ack_c2), .o_c_rdata(crd2), .o_d_ack(ack_d2), .o_d_rdata(drd2),
    .o_mem_addr(ma2), .o_mem_write_data(mwd2), .o_mem_memwrite(mw2), .o_mem_memread(mr2),
    .o_mem_sign_mask(mm2), .i_mem_read_data(mrd2), .o_busy(busy2), .o_owner(own2));
  // dut1 sees a word-addressed RAM; dut2 sees a value that counts consecutive memread cycles
  assign mrd1 = mem1[ma1[7:2]];
  assign mrd2 = 32'h3000_0000 | rcnt2;
  always @(posedge clk) begin
    if (mw1) for (int b = 0; b < 4; b++) if (mm1[b]) mem1[ma1[7:2]][b*8 +: 8] <= mwd1[b*8 +: 8];
    rcnt2 <= mr2 ? rcnt2 + 1 : 0;
  end
  always @(negedge clk) begin
    if (mr1) rd1++;
    if (mw1) begin wr1++; wa1 = ma1; end
    if (mr2) rd2++;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(negedge clk) if (ack_c1 || ack_d1) begin
    if (ack_c1 && ack_d1) chk("dual_ack1", 1, 0);
    if (q1.size() == 0) chk("unexpected_ack1", {31'd0, ack_d1}, 32'hFFFF_FFFF);
    else begin
      e1 = q1.pop_front();
      chk("port1", {31'd0, ack_d1}, {31'd0, e1.port});
      chk("cycle1", cyc, e1.cyc);
      chk("owner1", {31'd0, own1}, {31'd0, e1.port});
      chk("rdata1", ack_d1 ? drd1 : crd1, e1.rdata);
    end
  end
  always @(negedge clk) if (ack_c2 || ack_d2) begin
    if (ack_c2 && ack_d2) chk("dual_ack2", 1, 0);
    if (q2.size() == 0) chk("unexpected_ack2", {31'd0, ack_d2}, 32'hFFFF_FFFF);
    else begin
      e2 = q2.pop_front();
      chk("port2", {31'd0, ack_d2}, {31'd0, e2.port});
      chk("cycle2", cyc, e2.cyc);
      chk("owner2", {31'd0, own2}, {31'd0, e2.port});
      chk("rdata2", ack_d2 ? drd2 : crd2, e2.rdata);
    end
  end
  task automatic wait_ack(input int w, input string nm);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((w == 0 && ack_c1) || (w == 1 && ack_d1) || (w == 2 && ack_c2) || (w == 3 && ack_d2)) begin
        if (w == 0) cr1 = 0;
        if (w == 1) dr1 = 0;
        if (w == 2) cr2 = 0;
        if (w == 3) dr2 = 0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL timeout %s: no ack within 40 cycles", nm);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 64; i++) mem1[i] = 0;
    mem1[4] = 32'hDEAD_BEEF;
    mem1[5] = 32'hCAFE_F00D;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy1}, 0);
    chk("rst_owner", {31'd0, own1}, 1);
    chk("rst_mem", {ma1 | mwd1, 3'd0, mr1, mw1, mm1}, 0);
    chk("rst_ack_rdata", {ack_c1, ack_d1} | crd1 | drd1, 0);
    chk("rst_owner2", {31'd0, own2}, 1);
    rst_n = 1;
    rst_n2 = 1;
    // sustained dual requests under round-robin: C, D, C, D three cycles apart
    @(posedge clk); #1; k = cyc;
    cr1 = 1; ca_1 = 32'h10; dr1 = 1; da_1 = 32'h14;
    q1.push_back('{1'b0, 32'hDEAD_BEEF, k + 2});
    q1.push_back('{1'b1, 32'hCAFE_F00D, k + 5});
    q1.push_back('{1'b0, 32'hDEAD_BEEF, k + 8});
    q1.push_back('{1'b1, 32'hCAFE_F00D, k + 11});
    n = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clk);
      if (ack_c1 || ack_d1) begin
        n++;
        if (n == 3) cr1 = 0;
        if (n == 4) dr1 = 0;
      end
    end
    if (n < 4) chk("rr_ack_count", n, 4);
    // single C read at latency 1
    @(posedge clk); #1; k = cyc; r0 = rd1;
    cr1 = 1; cw1 = 0; ca_1 = 32'h10;
    q1.push_back('{1'b0, 32'hDEAD_BEEF, k + 2});
    wait_ack(0, "c_read");
    chk("c_read_memread_cycles", rd1 - r0, 1);
    // single D write
    @(posedge clk); #1; k = cyc; w0 = wr1;
    dr1 = 1; dw1 = 1; da_1 = 32'h20; dwd1 = 32'h1234_5678; dm1 = 4'hF;
    q1.push_back('{1'b1, 32'hCAFE_F00D, k + 2});
    wait_ack(1, "d_write");
    dw1 = 0;
    chk("d_write_pulses", wr1 - w0, 1);
    chk("d_write_addr", wa1, 32'h20);
    chk("d_write_mem", mem1[8], 32'h1234_5678);
    @(posedge clk); #1; k = cyc;
    cr1 = 1; ca_1 = 32'h20;
    q1.push_back('{1'b0, 32'h1234_5678, k + 2});
    wait_ack(0, "c_readback");
    // latency 3 read: value from the third ACCESS cycle
    @(posedge clk); #1; k = cyc; r0 = rd2;
    cr2 = 1; cw2 = 0; ca_2 = 32'h40;
    q2.push_back('{1'b0, 32'h3000_0002, k + 4});
    wait_ack(2, "lat3_read");
    chk("lat3_memread_cycles", rd2 - r0, 3);
    // CPU priority: C served while held, D after C drops
    @(posedge clk); #1; k = cyc;
    cr2 = 1; ca_2 = 32'h44; dr2 = 1; da_2 = 32'h48; dw2 = 0;
    q2.push_back('{1'b0, 32'h3000_0002, k + 4});
    q2.push_back('{1'b0, 32'h3000_0002, k + 9});
    q2.push_back('{1'b1, 32'h3000_0002, k + 14});
    n = 0;
    for (int i = 0; i < 60 && n < 3; i++) begin
      @(negedge clk);
      if (ack_c2 || ack_d2) begin
        n++;
        if (n == 2) cr2 = 0;
        if (n == 3) dr2 = 0;
      end
    end
    if (n < 3) chk("prio_ack_count", n, 3);
    // reset during ACCESS abandons the read
    @(posedge clk); #1;
    cr2 = 1; ca_2 = 32'h50;
    @(posedge clk); #2;
    chk("pre_rst_memread", {31'd0, mr2}, 1);
    rst_n2 = 0;
    #1;
    chk("rst_memread", {31'd0, mr2}, 0);
    chk("rst_busy2", {31'd0, busy2}, 0);
    chk("rst_owner2_mid", {31'd0, own2}, 1);
    chk("rst_rdata2", crd2, 0);
    cr2 = 0;
    @(negedge clk);
    rst_n2 = 1;
    repeat (6) @(posedge clk);
    #1; k = cyc;
    cr2 = 1; ca_2 = 32'h54;
    q2.push_back('{1'b0, 32'h3000_0002, k + 4});
    wait_ack(2, "post_rst_read");
    repeat (5) @(posedge clk);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between the CPU load/store unit (port C) and the debug/host access path (port D), e.g. a UART register/memory-poke engine.
- Sits between the cpu data-memory interface and data_memory, and owns every memwrite/memread strobe to the memory.
- Serialises accesses with a request/acknowledge handshake, round-robin or fixed-priority arbitration, and a programmable memory latency.

Parameters:
- MEM_LATENCY, 1, cycles from the memory strobe to valid read_data (legal range 1..15).
- CPU_PRIORITY, 0, 0 = round-robin between C and D; 1 = C always wins a tie.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- c_req / d_req  in  1  access request, held until the matching ack.
- c_we / d_we  in  1  1 = write, 0 = read.
- c_addr / d_addr  in  32  byte address.
- c_wdata / d_wdata  in  32  write data.
- c_mask / d_mask  in  4  sign/byte mask, passed to the memory unchanged.
- c_ack / d_ack  out  1  one-cycle completion pulse.
- c_rdata / d_rdata  out  32  read data, valid while ack is high and held until that port's next ack.
- mem_addr  out  32  to data_memory addr.
- mem_write_data  out  32  to data_memory write_data.
- mem_memwrite  out  1  to data_memory memwrite.
- mem_memread  out  1  to data_memory memread.
- mem_sign_mask  out  4  to data_memory sign_mask.
- mem_read_data  in  32  from data_memory read_data.
- busy  out  1  high in every state except IDLE.
- owner  out  1  0 = C, 1 = D; the current or most recent grantee.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state = IDLE; all mem_* outputs = 0; c_ack = d_ack = 0; rdata = 0; busy = 0.
  - owner = 1 (D), so C wins the first round-robin tie.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Any request: pick a winner and latch its addr/wdata/mask/we into the mem_* registers.
  - Set owner to the winner, load the counter with MEM_LATENCY-1, go to ACCESS.
- Winner selection:
  - Only one requester: that requester.
  - Both, CPU_PRIORITY = 1: C.
  - Both, CPU_PRIORITY = 0: the port that is not owner.
- ACCESS:
  - mem_addr, mem_write_data and mem_sign_mask are stable for the whole state.
  - Write: mem_memwrite is high on the first ACCESS cycle only (single write edge).
  - Read: mem_memread is high for all ACCESS cycles.
  - When the counter reaches 0, capture mem_read_data into the winner's rdata (reads only) and go to DONE.
  - Otherwise decrement the counter.
- DONE:
  - Pulse the winner's ack for 1 cycle.
  - mem_memread/mem_memwrite = 0 and mem_addr = 0.
  - Return to IDLE. No new grant is issued in DONE (one bubble).
- Latency and throughput:
  - Request seen in IDLE at cycle t -> ack at cycle t+MEM_LATENCY+1.
  - Back-to-back throughput is one access per MEM_LATENCY+2 cycles.
- Requester rules:
  - Fields must stay stable until ack; the arbiter samples them only in IDLE.
  - A requester must drop req in the ack cycle or it is treated as a new request.
- Request changes:
  - A request dropped before grant is ignored with no side effect.
  - A request dropped after grant still completes, and ack is still pulsed.
- Simultaneous events: the loser keeps waiting. Under round-robin, sustained dual requests alternate C, D, C, D…
- Reset mid-operation: all strobes drop asynchronously and the in-flight access is abandoned with no ack. The memory contents for an in-flight write are undefined only if rst_n falls in the same cycle as the write edge.
- Width rules: all data paths are passed through unmodified; no sign extension is done here (data_memory applies sign_mask).

Decomposition:
- Package dmem_arb_pkg:
  - State encoding (IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2).
  - Owner codes OWN_C = 1'b0, OWN_D = 1'b1.
  - Counter width constant (4 bits).
- Sub-module dmem_rr_pick: combinational 2-way picker with inputs c_req, d_req, last owner, CPU_PRIORITY and outputs grant_valid, grant_id.

Test Plan:
- Single C read, MEM_LATENCY = 1, c_addr = 0x00000010, memory holds 0xDEADBEEF there -> mem_memread high for 1 cycle, c_ack 2 cycles after req, c_rdata = 0xDEADBEEF, d_ack never asserted.
- Single D write, d_addr = 0x20, d_wdata = 0x12345678, d_mask = 4'hF -> mem_memwrite high for exactly 1 cycle with mem_addr = 0x20; a following C read of 0x20 returns 0x12345678.
- Both requests held continuously, CPU_PRIORITY = 0 -> grants C, D, C, D (owner toggles), acks 3 cycles apart at MEM_LATENCY = 1.
- Both requests held, CPU_PRIORITY = 1 -> only C is served while c_req stays high; D is served on the first IDLE cycle after c_req drops.
- MEM_LATENCY = 3 read -> mem_memread high for 3 cycles, ack at t+4, rdata captures the value present on the third ACCESS cycle.
- rst_n pulsed low during ACCESS of a C read -> mem_memread falls immediately, no c_ack, busy = 0, owner = 1; a new C request after reset completes normally.
